// File: rtl/spi_master_tx.sv
// Pixel SPI link transmitter: serialises valid/ready words MSB-first onto spi_clk/spi_mosi,
// with a hold register so consecutive words stream without gaps, and drives the receiver reset.
module spi_master_tx #(
  parameter int BITS_PER_PIXEL = 32,
  parameter int CLK_DIV        = 2,
  parameter int SYNC_CYCLES    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [BITS_PER_PIXEL-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      spi_clk,
  output logic                      spi_mosi,
  output logic                      spi_rst,
  output logic                      busy,
  output logic                      word_done
);

  localparam int BCW = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
  localparam int DW  = (CLK_DIV > 1)        ? $clog2(CLK_DIV)        : 1;
  localparam int SW  = (SYNC_CYCLES > 1)    ? $clog2(SYNC_CYCLES)    : 1;

  typedef enum logic [1:0] {
    S_SYNC,
    S_IDLE,
    S_LOW,
    S_HIGH
  } state_e;

  state_e                    state_q, state_d;
  logic [SW-1:0]             sync_cnt_q, sync_cnt_d;
  logic [DW-1:0]             div_cnt_q, div_cnt_d;
  logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
  logic [BITS_PER_PIXEL-1:0] hold_q, hold_d;
  logic                      hold_valid_q, hold_valid_d;
  logic                      spi_clk_q, spi_clk_d;
  logic                      spi_mosi_q, spi_mosi_d;
  logic                      spi_rst_q, spi_rst_d;
  logic                      in_ready_q, in_ready_d;
  logic                      busy_q, busy_d;
  logic                      word_done_q, word_done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_SYNC;
      sync_cnt_q   <= '0;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      spi_clk_q    <= 1'b0;
      spi_mosi_q   <= 1'b0;
      spi_rst_q    <= 1'b1;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_cnt_q   <= sync_cnt_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      spi_clk_q    <= spi_clk_d;
      spi_mosi_q   <= spi_mosi_d;
      spi_rst_q    <= spi_rst_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      word_done_q  <= word_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sync_cnt_d   = sync_cnt_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    spi_clk_d    = spi_clk_q;
    spi_mosi_d   = spi_mosi_q;
    spi_rst_d    = spi_rst_q;
    busy_d       = busy_q;
    word_done_d  = 1'b0;

    case (state_q)
      S_SYNC: begin
        spi_rst_d = 1'b1;
        if (sync_cnt_q == SW'(SYNC_CYCLES - 1)) begin
          spi_rst_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          sync_cnt_d = sync_cnt_q + SW'(1);
        end
      end
      S_IDLE: begin
        spi_clk_d = 1'b0;
        busy_d    = 1'b0;
        if (hold_valid_q) begin
          shift_d      = hold_q;
          spi_mosi_d   = hold_q[BITS_PER_PIXEL-1];
          bit_cnt_d    = BCW'(BITS_PER_PIXEL - 1);
          div_cnt_d    = '0;
          hold_valid_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_LOW;
        end
      end
      S_LOW: begin
        if (div_cnt_q == DW'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          spi_clk_d = 1'b1;
          state_d   = S_HIGH;
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      S_HIGH: begin
        if (div_cnt_q == DW'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          spi_clk_d = 1'b0;
          if (bit_cnt_q != '0) begin
            bit_cnt_d  = bit_cnt_q - BCW'(1);
            shift_d    = shift_q << 1;
            spi_mosi_d = shift_d[BITS_PER_PIXEL-1];
            state_d    = S_LOW;
          end else begin
            word_done_d = 1'b1;
            // Reload straight from the hold register so the next word follows with no idle cycle.
            if (hold_valid_q) begin
              shift_d      = hold_q;
              spi_mosi_d   = hold_q[BITS_PER_PIXEL-1];
              bit_cnt_d    = BCW'(BITS_PER_PIXEL - 1);
              hold_valid_d = 1'b0;
              state_d      = S_LOW;
            end else begin
              spi_mosi_d = 1'b0;
              busy_d     = 1'b0;
              state_d    = S_IDLE;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      default: state_d = S_SYNC;
    endcase

    if (in_valid && in_ready_q) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
    end

    in_ready_d = !hold_valid_d && (state_d != S_SYNC);
  end

  assign in_ready  = in_ready_q;
  assign spi_clk   = spi_clk_q;
  assign spi_mosi  = spi_mosi_q;
  assign spi_rst   = spi_rst_q;
  assign busy      = busy_q;
  assign word_done = word_done_q;

endmodule
